// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Shares one line-wide L2 request port between the L1 I-cache and L1 D-cache
// miss interfaces. Only one L2 transaction is outstanding at a time. When both
// caches request in the same IDLE cycle, the one that did not win the previous
// tie is granted. The winner's address, write line and operation are latched so
// the L2 sees stable inputs for the whole transaction. Every completion is
// followed by one bubble cycle (DONE), which gives the requester time to drop
// its request before arbitration runs again.
//
// Optional feature (macro L2_ARB_PERF_CNT_EN):
//   Adds the grant counters i_grant_cnt/d_grant_cnt and stall_cnt. stall_cnt
//   counts cycles where one side waits while the other side is being served.
//   When the macro is undefined these ports do not exist.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_read/i_address             I-cache line read request (held until i_resp)
//   i_rdata/i_resp               line and one-cycle completion to the I-cache
//   d_read/d_write/d_address     D-cache request (held until d_resp)
//   d_wdata                      D-cache write line
//   d_rdata/d_resp               line and one-cycle completion to the D-cache
//   l2_read/l2_write             L2 strobes, held until l2_resp
//   l2_address/l2_wdata          latched address / write line of the grant
//   l2_rdata/l2_resp             L2 read line and one-cycle completion
// ---------------------------------------------------------------------------
module l2_arbiter #(
    parameter int width  = 256,
    parameter int awidth = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef L2_ARB_PERF_CNT_EN
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       stall_cnt,
`endif
    input  logic              i_read,
    input  logic [awidth-1:0] i_address,
    output logic [width-1:0]  i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [awidth-1:0] d_address,
    input  logic [width-1:0]  d_wdata,
    output logic [width-1:0]  d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [awidth-1:0] l2_address,
    output logic [width-1:0]  l2_wdata,
    input  logic [width-1:0]  l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state_reg, state_next;
    logic   last_grant_reg, last_grant_next;

    logic              l2_read_reg;
    logic              l2_write_reg;
    logic [awidth-1:0] l2_address_reg;
    logic [width-1:0]  l2_wdata_reg;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_D;   // I-cache wins the first tie
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // last_grant only moves when a tie is resolved; a lone requester is
    // granted without disturbing the tie-break history.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_grant_reg == GRANT_D) begin
                        state_next      = SERVE_I;
                        last_grant_next = GRANT_I;
                    end else begin
                        state_next      = SERVE_D;
                        last_grant_next = GRANT_D;
                    end
                end else if (i_req) begin
                    state_next = SERVE_I;
                end else if (d_req) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: completions are a combinational pass-through of l2_resp
    // while the matching side is being served. Gating with rst keeps a
    // response arriving in the reset cycle from leaking to a requester.
    // -----------------------------------------------------------------------
    always_comb begin
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (!rst && l2_resp) begin
            if (state_reg == SERVE_I) begin
                i_resp  = 1'b1;
                i_rdata = l2_rdata;
            end else if (state_reg == SERVE_D) begin
                d_resp  = 1'b1;
                d_rdata = l2_rdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request latch toward the L2. Loaded on the IDLE->SERVE edge, strobes
    // cleared on the completion edge so they are low in DONE.
    // -----------------------------------------------------------------------
    assign grant_i = (state_reg == IDLE) && (state_next == SERVE_I);
    assign grant_d = (state_reg == IDLE) && (state_next == SERVE_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            l2_read_reg    <= 1'b0;
            l2_write_reg   <= 1'b0;
            l2_address_reg <= '0;
            l2_wdata_reg   <= '0;
        end else if (grant_i) begin
            l2_read_reg    <= 1'b1;
            l2_write_reg   <= 1'b0;
            l2_address_reg <= i_address;
            l2_wdata_reg   <= '0;
        end else if (grant_d) begin
            // A simultaneous read and write from the D-cache is a write.
            l2_read_reg    <= d_read & ~d_write;
            l2_write_reg   <= d_write;
            l2_address_reg <= d_address;
            l2_wdata_reg   <= d_wdata;
        end else if (((state_reg == SERVE_I) || (state_reg == SERVE_D)) && l2_resp) begin
            l2_read_reg    <= 1'b0;
            l2_write_reg   <= 1'b0;
        end
    end

    assign l2_read    = l2_read_reg;
    assign l2_write   = l2_write_reg;
    assign l2_address = l2_address_reg;
    assign l2_wdata   = l2_wdata_reg;

`ifdef L2_ARB_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // -----------------------------------------------------------------------
    logic [31:0] i_grant_cnt_reg;
    logic [31:0] d_grant_cnt_reg;
    logic [31:0] stall_cnt_reg;
    logic        stall;

    // At most one side can be waiting while the other is served.
    assign stall = ((state_reg == SERVE_I) && d_req) ||
                   ((state_reg == SERVE_D) && i_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_cnt_reg <= '0;
            d_grant_cnt_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            if (grant_i) i_grant_cnt_reg <= i_grant_cnt_reg + 32'd1;
            if (grant_d) d_grant_cnt_reg <= d_grant_cnt_reg + 32'd1;
            if (stall)   stall_cnt_reg   <= stall_cnt_reg + 32'd1;
        end
    end

    assign i_grant_cnt = i_grant_cnt_reg;
    assign d_grant_cnt = d_grant_cnt_reg;
    assign stall_cnt   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_arbiter
//
// Self-checking bench for l2_arbiter. The bench plays both L1 requesters and
// the L2. A small reference model (pending requests per side plus the tie-break
// history) predicts which side is granted, what the L2 must see, when the
// strobe must rise, and what each requester must receive. Inputs change on the
// falling edge; outputs are sampled shortly after it.
// Build with +define+L2_ARB_PERF_CNT_EN to also exercise the counters.
// ---------------------------------------------------------------------------
module tb_l2_arbiter;

    localparam int W  = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [W-1:0]  i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [W-1:0]  d_wdata;
    logic [W-1:0]  d_rdata;
    logic          d_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_address;
    logic [W-1:0]  l2_wdata;
    logic [W-1:0]  l2_rdata;
    logic          l2_resp;
`ifdef L2_ARB_PERF_CNT_EN
    logic [31:0]   i_grant_cnt;
    logic [31:0]   d_grant_cnt;
    logic [31:0]   stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int rr_last;     // model: side that won the last tie (0 = I, 1 = D)

    always #5 clk = ~clk;

    l2_arbiter #(.width(W), .awidth(AW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef L2_ARB_PERF_CNT_EN
        .i_grant_cnt(i_grant_cnt),
        .d_grant_cnt(d_grant_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp)
    );

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] v;
        for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    // Model of the arbitration rule: lone requester wins; on a tie the side
    // that did not win the previous tie wins, and becomes the new tie winner.
    task automatic pick(input bit ireq, input bit dreq, output int winner);
        if (ireq && dreq) begin
            winner  = (rr_last == 1) ? 0 : 1;
            rr_last = winner;
        end else if (ireq) begin
            winner = 0;
        end else begin
            winner = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        l2_rdata  = '0;
        l2_resp   = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        rr_last = 1;
    endtask

    // Acts as the L2 for one transaction. Waits for the strobe (expected after
    // exp_wait falling edges), holds it for k cycles, then answers and checks
    // the completion on the expected side and the DONE bubble that follows.
    task automatic l2_serve(input int side, input bit wr, input logic [AW-1:0] addr,
                            input logic [W-1:0] wdata, input int k, input int exp_wait,
                            input bit drop);
        int n;
        logic [W-1:0] rd;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(l2_read || l2_write) && n < 12);
        checks++;
        if (n != exp_wait) begin
            failures++;
            $display("FAIL strobe_latency side=%0d got=%0d cycles required=%0d", side, n, exp_wait);
        end
        checks++;
        if (l2_read !== !wr || l2_write !== wr) begin
            failures++;
            $display("FAIL l2_op side=%0d got read=%b write=%b required write=%b", side, l2_read, l2_write, wr);
        end
        checks++;
        if (l2_address !== addr) begin
            failures++;
            $display("FAIL l2_address side=%0d got=%h required=%h", side, l2_address, addr);
        end
        if (wr) begin
            checks++;
            if (l2_wdata !== wdata) begin
                failures++;
                $display("FAIL l2_wdata got=%h required=%h", l2_wdata, wdata);
            end
        end
        for (int c = 0; c < k; c++) begin
            checks++;
            if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0 ||
                l2_read !== !wr || l2_write !== wr || l2_address !== addr) begin
                failures++;
                $display("FAIL serve_hold cycle=%0d got read=%b write=%b ir=%b dr=%b addr=%h required addr=%h",
                         c, l2_read, l2_write, i_resp, d_resp, l2_address, addr);
            end
            @(negedge clk); #1;
        end
        rd       = rand_line();
        l2_rdata = rd;
        l2_resp  = 1'b1;
        #1;
        checks++;
        if (l2_read !== !wr || l2_write !== wr) begin
            failures++;
            $display("FAIL strobe_at_resp got read=%b write=%b required write=%b", l2_read, l2_write, wr);
        end
        checks++;
        if (side == 0) begin
            if (i_resp !== 1'b1 || i_rdata !== rd || d_resp !== 1'b0 || d_rdata !== '0) begin
                failures++;
                $display("FAIL i_complete got i_resp=%b d_resp=%b i_rdata_ok=%b required i_resp=1 d_resp=0",
                         i_resp, d_resp, (i_rdata === rd));
            end
        end else begin
            if (d_resp !== 1'b1 || d_rdata !== rd || i_resp !== 1'b0 || i_rdata !== '0) begin
                failures++;
                $display("FAIL d_complete got d_resp=%b i_resp=%b d_rdata_ok=%b required d_resp=1 i_resp=0",
                         d_resp, i_resp, (d_rdata === rd));
            end
        end
        if (drop) begin
            if (side == 0) i_read = 1'b0;
            else begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
        // DONE bubble: a stray l2_resp here must be ignored.
        @(negedge clk);
        l2_rdata = rand_line();
        l2_resp  = 1'b1;
        #1;
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0 ||
            i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL done_bubble got read=%b write=%b i_resp=%b d_resp=%b required all 0",
                     l2_read, l2_write, i_resp, d_resp);
        end
        #1;
        l2_resp = 1'b0;
        $display("txn side=%s write=%0b addr=%h hold=%0d wait=%0d", (side == 0) ? "I" : "D", wr, addr, k, n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        l2_resp  = 1'b1;
        l2_rdata = rand_line();
        i_read   = 1'b1;
        d_read   = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || l2_address !== '0 || l2_wdata !== '0 ||
            i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got read=%b write=%b addr=%h i_resp=%b d_resp=%b required all 0",
                     l2_read, l2_write, l2_address, i_resp, d_resp);
        end
`ifdef L2_ARB_PERF_CNT_EN
        checks++;
        if (i_grant_cnt !== 32'd0 || d_grant_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got i=%0d d=%0d stall=%0d required 0", i_grant_cnt, d_grant_cnt, stall_cnt);
        end
`endif
        $display("txn reset checked");
        do_reset();
    endtask

    task automatic test_single_i();
        int w;
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h0000_0100;
        pick(1'b1, 1'b0, w);
        l2_serve(w, 1'b0, 32'h0000_0100, '0, 2, 1, 1'b1);
    endtask

    task automatic test_tie_from_reset();
        int w;
        logic [W-1:0] wd;
        wd        = rand_line();
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h0000_2000;
        d_write   = 1'b1;
        d_address = 32'h0000_3000;
        d_wdata   = wd;
        pick(1'b1, 1'b1, w);
        l2_serve(w, 1'b0, 32'h0000_2000, '0, 1, 1, 1'b1);
        pick(1'b0, 1'b1, w);
        l2_serve(w, 1'b1, 32'h0000_3000, wd, 0, 2, 1'b1);
    endtask

    task automatic test_alternate();
        int w;
        int order[4];
        logic [W-1:0] wd;
        wd = rand_line();
        do_reset();
        i_read    = 1'b1;
        i_address = $urandom();
        d_read    = 1'b1;
        d_address = $urandom();
        d_wdata   = wd;
        for (int t = 0; t < 4; t++) begin
            pick(1'b1, 1'b1, w);
            order[t] = w;
            l2_serve(w, 1'b0, (w == 0) ? i_address : d_address, '0,
                     int'($urandom_range(0, 3)), (t == 0) ? 1 : 2, 1'b0);
        end
        checks++;
        if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            failures++;
            $display("FAIL alternate_order got=%0d%0d%0d%0d required=0101", order[0], order[1], order[2], order[3]);
        end
        i_read = 1'b0;
        d_read = 1'b0;
    endtask

    task automatic test_rw_conflict();
        int w;
        int seen;
        logic [W-1:0] wd;
        wd = rand_line();
        do_reset();
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'hCAFE_0040;
        d_wdata   = wd;
        pick(1'b0, 1'b1, w);
        l2_serve(w, 1'b1, 32'hCAFE_0040, wd, 2, 1, 1'b1);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (d_resp === 1'b1 || l2_read === 1'b1 || l2_write === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rw_conflict_quiet got=%0d active cycles required=0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        d_read    = 1'b1;
        d_address = 32'h0000_7700;
        @(negedge clk); #1;
        checks++;
        if (l2_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_setup got l2_read=%b required=1", l2_read);
        end
        rst    = 1'b1;
        d_read = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        rr_last  = 1;
        l2_rdata = rand_line();
        l2_resp  = 1'b1;
        #1;
        checks++;
        if (d_resp !== 1'b0 || d_rdata !== '0 || l2_read !== 1'b0 || l2_write !== 1'b0 ||
            l2_address !== '0 || l2_wdata !== '0) begin
            failures++;
            $display("FAIL late_resp_after_reset got d_resp=%b read=%b write=%b addr=%h required 0",
                     d_resp, l2_read, l2_write, l2_address);
        end
        @(negedge clk);
        l2_resp   = 1'b0;
        i_read    = 1'b1;
        i_address = 32'h0000_1234;
        d_read    = 1'b1;
        pick(1'b1, 1'b1, w);
        l2_serve(w, 1'b0, 32'h0000_1234, '0, 0, 1, 1'b1);
        pick(1'b0, 1'b1, w);
        l2_serve(w, 1'b0, 32'h0000_7700, '0, 1, 2, 1'b1);
    endtask

    task automatic test_random();
        bit i_pend, d_pend, first;
        int w;
        int op;
        do_reset();
        i_pend = 1'b0;
        d_pend = 1'b0;
        first  = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (!i_pend && ($urandom_range(0, 1) == 1)) begin
                i_pend    = 1'b1;
                i_read    = 1'b1;
                i_address = $urandom();
            end
            if (!d_pend && (($urandom_range(0, 1) == 1) || !i_pend)) begin
                d_pend    = 1'b1;
                op        = int'($urandom_range(0, 2));
                d_read    = (op != 1);
                d_write   = (op != 0);
                d_address = $urandom();
                d_wdata   = rand_line();
            end
            pick(i_pend, d_pend, w);
            if (w == 0) begin
                l2_serve(0, 1'b0, i_address, '0, int'($urandom_range(0, 4)), first ? 1 : 2, 1'b1);
                i_pend = 1'b0;
            end else begin
                l2_serve(1, d_write, d_address, d_wdata, int'($urandom_range(0, 4)), first ? 1 : 2, 1'b1);
                d_pend = 1'b0;
            end
            first = 1'b0;
        end
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef L2_ARB_PERF_CNT_EN
    task automatic test_perf_counters();
        int w;
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h10;
        pick(1'b1, 1'b0, w);
        l2_serve(w, 1'b0, 32'h10, '0, 1, 1, 1'b1);
        i_read    = 1'b1;
        i_address = 32'h20;
        d_read    = 1'b1;
        d_address = 32'h30;
        pick(1'b1, 1'b1, w);
        // D waits through all 5 serve cycles of this I transaction.
        l2_serve(w, 1'b0, 32'h20, '0, 4, 2, 1'b1);
        pick(1'b0, 1'b1, w);
        l2_serve(w, 1'b0, 32'h30, '0, 0, 2, 1'b1);
        i_read    = 1'b1;
        i_address = 32'h40;
        pick(1'b1, 1'b0, w);
        l2_serve(w, 1'b0, 32'h40, '0, 0, 2, 1'b1);
        d_write   = 1'b1;
        d_address = 32'h50;
        d_wdata   = rand_line();
        pick(1'b0, 1'b1, w);
        l2_serve(w, 1'b1, 32'h50, d_wdata, 1, 2, 1'b1);
        @(negedge clk); #1;
        checks++;
        if (i_grant_cnt !== 32'd3 || d_grant_cnt !== 32'd2 || stall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL perf_counters got i=%0d d=%0d stall=%0d required i=3 d=2 stall=5",
                     i_grant_cnt, d_grant_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        l2_rdata  = '0;
        l2_resp   = 1'b0;
        rr_last   = 1;
        test_reset();
        test_single_i();
        test_tie_from_reset();
        test_alternate();
        test_rw_conflict();
        test_reset_mid();
        test_random();
`ifdef L2_ARB_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
